vec_pingpong_buffer: RTL and testbench

//  Inter-layer vector store that serves chunked input to an MVProd stage and collects its serial output.

---
 rtl/vecbuf_pkg.sv | 15 +
 rtl/vec_chunk_packer.sv | 70 +++++++
 rtl/vec_pingpong_buffer.sv | 145 ++++++++++++++
 tb/tb_vec_pingpong_buffer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/vecbuf_pkg.sv
// Shared types and sizing helpers for the ping-pong vector buffer.
package vecbuf_pkg;

    localparam int DEF_VEC_LENGTH   = 16;
    localparam int DEF_WORKING_REGS = 4;

    typedef logic signed [7:0] elem_t;
    typedef logic signed [DEF_WORKING_REGS-1:0][7:0] chunk_t;
    typedef logic bank_idx_t;

    function automatic int num_chunks(input int vec_len, input int regs);
        return vec_len / regs;
    endfunction

endpackage

// File: rtl/vec_chunk_packer.sv
// Packs a serial stream of int8 elements into WorkingRegs-lane chunks, reporting
// each completed chunk with its index and the end of every vector.
module vec_chunk_packer
    import vecbuf_pkg::*;
#(
    parameter  int VecLength   = DEF_VEC_LENGTH,
    parameter  int WorkingRegs = DEF_WORKING_REGS,
    localparam int NumChunks   = num_chunks(VecLength, WorkingRegs),
    localparam int LaneW       = (WorkingRegs > 1) ? $clog2(WorkingRegs) : 1,
    localparam int ChunkW      = (NumChunks > 1) ? $clog2(NumChunks) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         elem_valid_i,
    input  elem_t                        elem_data_i,
    output logic                         chunk_valid_o,
    output logic [WorkingRegs-1:0][7:0]  chunk_o,
    output logic [ChunkW-1:0]            chunk_idx_o,
    output logic                         vec_done_o
);

    localparam logic [LaneW-1:0]  LastLane  = LaneW'(WorkingRegs - 1);
    localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NumChunks - 1);

    logic [LaneW-1:0]                lane_q, lane_d;
    logic [ChunkW-1:0]               chunk_q, chunk_d;
    logic [WorkingRegs-1:0][7:0]     staging_q, staging_d;
    logic                            last_lane, last_chunk;

    assign last_lane   = (lane_q == LastLane);
    assign last_chunk  = (chunk_q == LastChunk);
    assign chunk_idx_o = chunk_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        lane_d    = lane_q;
        chunk_d   = chunk_q;
        staging_d = staging_q;

        // The incoming element completes the chunk directly, so the RAM write needs no extra cycle.
        chunk_o          = staging_q;
        chunk_o[lane_q]  = elem_data_i;
        chunk_valid_o    = elem_valid_i && last_lane;
        vec_done_o       = chunk_valid_o && last_chunk;

        if (elem_valid_i) begin
            staging_d[lane_q] = elem_data_i;
            if (last_lane) begin
                lane_d  = '0;
                chunk_d = last_chunk ? '0 : chunk_q + 1'b1;
            end else begin
                lane_d  = lane_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q    <= '0;
            chunk_q   <= '0;
            staging_q <= '0;
        end else begin
            lane_q    <= lane_d;
            chunk_q   <= chunk_d;
            staging_q <= staging_d;
        end
    end

endmodule

// File: rtl/vec_pingpong_buffer.sv
// Two-bank ping-pong vector store between MVProd stages: serial int8 writes, chunked reads.
// Optional sticky overflow_out is enabled with `define VECBUF_OVERFLOW_FLAG_EN.
module vec_pingpong_buffer
    import vecbuf_pkg::*;
#(
    parameter int VecLength   = DEF_VEC_LENGTH,
    parameter int WorkingRegs = DEF_WORKING_REGS
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               wr_valid_in,
    input  logic signed [7:0]                  wr_data_in,
    output logic                               wr_full_out,
    output logic                               rd_ready_out,
    input  logic                               rd_req_in,
    input  logic                               rd_ptr_rst_in,
    input  logic                               rd_release_in,
`ifdef VECBUF_OVERFLOW_FLAG_EN
    output logic                               overflow_out,
`endif
    output logic signed [WorkingRegs-1:0][7:0] rd_data_out
);

    localparam int NumChunks = num_chunks(VecLength, WorkingRegs);
    localparam int ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;
    localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NumChunks - 1);

    if (VecLength % WorkingRegs != 0) begin : g_bad_cfg
        $error("vec_pingpong_buffer: VecLength must be a multiple of WorkingRegs");
    end

    logic [1:0]                  full_q, full_d;
    bank_idx_t                   wr_bank_q, wr_bank_d;
    bank_idx_t                   rd_bank_q, rd_bank_d;
    logic [ChunkW-1:0]           rd_ptr_q, rd_ptr_d;
    logic                        rd_ready_q, wr_full_q;
    logic [WorkingRegs-1:0][7:0] rd_data_q, rd_data_d, rd_word;
    logic [WorkingRegs-1:0][7:0] mem_q [2][NumChunks];

    logic                        wr_accept, release_ok;
    logic                        chunk_valid, vec_done;
    logic [WorkingRegs-1:0][7:0] chunk;
    logic [ChunkW-1:0]           chunk_idx;

    assign wr_accept  = wr_valid_in && !full_q[wr_bank_q];
    assign release_ok = rd_release_in && rd_ready_q;

    vec_chunk_packer #(
        .VecLength   (VecLength),
        .WorkingRegs (WorkingRegs)
    ) u_packer (
        .clk           (clk_in),
        .rst_n         (rst_n_in),
        .elem_valid_i  (wr_accept),
        .elem_data_i   (wr_data_in),
        .chunk_valid_o (chunk_valid),
        .chunk_o       (chunk),
        .chunk_idx_o   (chunk_idx),
        .vec_done_o    (vec_done)
    );

    // Fill and release always target different banks, so both may land in one cycle.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        rd_ptr_d  = rd_ptr_q;

        if (vec_done) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end

        if (release_ok) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_ptr_d          = '0;
        end else if (rd_ptr_rst_in) begin
            rd_ptr_d = '0;
        end else if (rd_req_in && rd_ready_q) begin
            rd_ptr_d = (rd_ptr_q == LastChunk) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    // Read from the next-state address so data tracks rd_ready_out with no extra cycle;
    // a chunk being written this cycle to the same slot is forwarded.
    always_comb begin
        rd_word = mem_q[rd_bank_d][rd_ptr_d];
        if (chunk_valid && (wr_bank_q == rd_bank_d) && (chunk_idx == rd_ptr_d)) begin
            rd_word = chunk;
        end
        rd_data_d = full_d[rd_bank_d] ? rd_word : '0;
    end

    // NOTE: the bank RAM has no reset so it can map onto distributed/block RAM; full flags guard stale data.
    always_ff @(posedge clk_in) begin
        if (chunk_valid) begin
            mem_q[wr_bank_q][chunk_idx] <= chunk;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_ptr_q   <= '0;
            rd_ready_q <= 1'b0;
            wr_full_q  <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_ready_q <= full_d[rd_bank_d];
            wr_full_q  <= full_d[0] & full_d[1];
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_ready_out = rd_ready_q;
    assign wr_full_out  = wr_full_q;
    assign rd_data_out  = rd_data_q;

`ifdef VECBUF_OVERFLOW_FLAG_EN
    logic overflow_q;
    logic wr_drop;

    assign wr_drop = wr_valid_in && full_q[wr_bank_q];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            overflow_q <= 1'b0;
        end else if (wr_drop || (!rd_ready_q && (rd_req_in || rd_release_in))) begin
            overflow_q <= 1'b1;
        end
    end

    assign overflow_out = overflow_q;
`else
    // Without the flag, dropped writes and early read requests are silently ignored.
`endif

endmodule

// File: tb/tb_vec_pingpong_buffer.sv
// Directed self-checking bench for vec_pingpong_buffer (VecLength=16, WorkingRegs=4).
module tb_vec_pingpong_buffer;
    import vecbuf_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   wr_valid;
    elem_t  wr_data;
    logic   wr_full;
    logic   rd_ready;
    logic   rd_req;
    logic   rd_ptr_rst;
    logic   rd_release;
    chunk_t rd_data;
`ifdef VECBUF_OVERFLOW_FLAG_EN
    logic   overflow;
`endif

    int errors = 0;
    int checks = 0;

    vec_pingpong_buffer #(
        .VecLength   (16),
        .WorkingRegs (4)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .wr_valid_in   (wr_valid),
        .wr_data_in    (wr_data),
        .wr_full_out   (wr_full),
        .rd_ready_out  (rd_ready),
        .rd_req_in     (rd_req),
        .rd_ptr_rst_in (rd_ptr_rst),
        .rd_release_in (rd_release),
`ifdef VECBUF_OVERFLOW_FLAG_EN
        .overflow_out  (overflow),
`endif
        .rd_data_out   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write_elems(input logic [7:0] base, input int count);
        for (int i = 0; i < count; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 8'(i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic pulse_release();
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        rd_req     = 1'b0;
        rd_ptr_rst = 1'b0;
        rd_release = 1'b0;
        tick();
        tick();
        check("reset_rd_data", rd_data, 32'h0);
        check("reset_rd_ready", {31'b0, rd_ready}, 32'h0);
        check("reset_wr_full", {31'b0, wr_full}, 32'h0);
`ifdef VECBUF_OVERFLOW_FLAG_EN
        check("reset_overflow", {31'b0, overflow}, 32'h0);
`endif
        rst_n = 1'b1;
        tick();

        // 1: fill one vector 0..15
        write_elems(8'h00, 15);
        check("t1_not_ready_before_last", {31'b0, rd_ready}, 32'h0);
        write_elems(8'h0f, 1);
        check("t1_ready", {31'b0, rd_ready}, 32'h1);
        check("t1_chunk0", rd_data, 32'h03020100);
        check("t1_not_full", {31'b0, wr_full}, 32'h0);

        // 2: step through chunks and wrap
        rd_req = 1'b1;
        tick();
        check("t2_chunk1", rd_data, 32'h07060504);
        tick();
        check("t2_chunk2", rd_data, 32'h0b0a0908);
        tick();
        check("t2_chunk3", rd_data, 32'h0f0e0d0c);
        tick();
        check("t2_wrap", rd_data, 32'h03020100);
        rd_req = 1'b0;

        // 3: rewind beats advance
        rd_req = 1'b1;
        tick();
        tick();
        check("t3_at_chunk2", rd_data, 32'h0b0a0908);
        rd_ptr_rst = 1'b1;
        tick();
        rd_ptr_rst = 1'b0;
        rd_req     = 1'b0;
        check("t3_rewound", rd_data, 32'h03020100);

        // 4: release, request while empty, two vectors, dropped third
        pulse_release();
        check("t4_empty_after_release", {31'b0, rd_ready}, 32'h0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        write_elems(8'h10, 16);
        check("t4_A_ready", {31'b0, rd_ready}, 32'h1);
        check("t4_A_chunk0", rd_data, 32'h13121110);
        write_elems(8'h20, 16);
        check("t4_full", {31'b0, wr_full}, 32'h1);
        write_elems(8'h30, 16);
        check("t4_drop_keeps_A", rd_data, 32'h13121110);
        check("t4_still_full", {31'b0, wr_full}, 32'h1);
`ifdef VECBUF_OVERFLOW_FLAG_EN
        check("t4_overflow", {31'b0, overflow}, 32'h1);
`endif
        pulse_release();
        check("t4_B_ready", {31'b0, rd_ready}, 32'h1);
        check("t4_B_chunk0", rd_data, 32'h23222120);
        check("t4_not_full", {31'b0, wr_full}, 32'h0);
        pulse_release();
        check("t4_third_dropped", {31'b0, rd_ready}, 32'h0);

        // 5: stray release while empty, then completion coincident with release
        pulse_release();
        write_elems(8'h50, 16);
        check("t5_A2_ready", {31'b0, rd_ready}, 32'h1);
        check("t5_A2_chunk0", rd_data, 32'h53525150);
        write_elems(8'h60, 15);
        wr_valid   = 1'b1;
        wr_data    = 8'h6f;
        rd_release = 1'b1;
        tick();
        wr_valid   = 1'b0;
        rd_release = 1'b0;
        check("t5_ready_kept", {31'b0, rd_ready}, 32'h1);
        check("t5_B2_chunk0", rd_data, 32'h63626160);
        check("t5_not_full", {31'b0, wr_full}, 32'h0);

        // 6: asynchronous reset mid-vector, then refill from element 0
        write_elems(8'h70, 7);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_rd_ready", {31'b0, rd_ready}, 32'h0);
        check("t6_rst_rd_data", rd_data, 32'h0);
        check("t6_rst_wr_full", {31'b0, wr_full}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        write_elems(8'ha0, 16);
        check("t6_refill_ready", {31'b0, rd_ready}, 32'h1);
        check("t6_refill_chunk0", rd_data, 32'ha3a2a1a0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("t6_refill_chunk1", rd_data, 32'ha7a6a5a4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
